// File: rtl/vga_timing_1024.sv
// vga_timing_1024: free-running raster timing generator, XGA 1024x768@60 by default.
// Latency: every output is a flop loaded from the next-state counters, so flags line up with hcount/vcount.
// Backpressure: none; the counters advance on every clock and never stall.
//
// Ports:
//   clk         pixel clock
//   rst         asynchronous reset, active low
//   hcount      pixel index within the line, 0..H_TOTAL-1
//   vcount      line index within the frame, 0..V_TOTAL-1
//   hblnk       high while hcount >= H_ACTIVE
//   vblnk       high while vcount >= V_ACTIVE
//   hsync       SYNC_POL inside the horizontal sync window, ~SYNC_POL elsewhere
//   vsync       SYNC_POL inside the vertical sync window (whole lines), ~SYNC_POL elsewhere
//   frame_start one-clock strobe at (0,0) after a full-frame wrap, never right after reset
module vga_timing_1024 #(
    parameter int   H_ACTIVE = 1024,
    parameter int   H_FP     = 24,
    parameter int   H_SYNC   = 136,
    parameter int   H_BP     = 160,
    parameter int   V_ACTIVE = 768,
    parameter int   V_FP     = 3,
    parameter int   V_SYNC   = 6,
    parameter int   V_BP     = 29,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        hblnk,
    output logic        vblnk,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Both totals must fit the 11-bit counters.
    if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_size_check
        $error("vga_timing_1024: H_TOTAL/V_TOTAL exceed 11-bit counter range");
    end

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_BLNK_BEG = 11'(H_ACTIVE);
    localparam logic [10:0] V_BLNK_BEG = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG     = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);   // exclusive
    localparam logic [10:0] VS_BEG     = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);   // exclusive

    logic        h_wrap;
    logic        v_wrap;
    logic [10:0] h_next;
    logic [10:0] v_next;

    always_comb begin
        h_wrap = (hcount == H_LAST);
        v_wrap = (vcount == V_LAST);
        h_next = h_wrap ? 11'd0 : hcount + 11'd1;
        v_next = vcount;
        if (h_wrap) begin
            v_next = v_wrap ? 11'd0 : vcount + 11'd1;
        end
    end

    // Flags are decoded from h_next/v_next so they land in the same cycle
    // as the counter value they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount      <= 11'd0;
            vcount      <= 11'd0;
            hblnk       <= 1'b0;
            vblnk       <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            hcount      <= h_next;
            vcount      <= v_next;
            hblnk       <= (h_next >= H_BLNK_BEG);
            vblnk       <= (v_next >= V_BLNK_BEG);
            hsync       <= (h_next >= HS_BEG && h_next < HS_END) ? SYNC_POL : ~SYNC_POL;
            vsync       <= (v_next >= VS_BEG && v_next < VS_END) ? SYNC_POL : ~SYNC_POL;
            // Only a genuine wrap from the last pixel of the last line
            // produces the strobe; the reset (0,0) state does not.
            frame_start <= h_wrap && v_wrap;
        end
    end

endmodule
